unpacker_8to12: RTL and testbench
=================================

# unpacker_8to12

Reassembles 12-bit ADC samples from the byte stream produced by the 12-to-8 packer; it is the receive-side inverse of that packer. Every 3 input bytes carry 2 samples. It sits after the byte transport (USB/FIFO readback path or loopback test path) and feeds sample consumers or checkers with the same valid-only strobe interface the ADC block uses.

## Interface

Parameters:
- none. Widths are fixed by the packing format: 12-bit samples, 8-bit bytes.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  packed byte.
- `in_valid`  in  1  `in_data` is consumed on every cycle where this is high. There is no backpressure.
- `resync`  in  1  synchronous. Discards any partial triplet and forces phase 0.
- `out_data`  out  12  reassembled sample.
- `out_valid`  out  1  one-cycle strobe; `out_data` is valid in that cycle.
- `phase`  out  2  current byte phase (0, 1, 2), for debug and alignment checking.

## Operation

Packing format, little-endian, for sample pair A (first) and B (second):
- byte0 = A[7:0]
- byte1 = {B[3:0], A[11:8]}
- byte2 = B[11:4]

Phase state machine. It advances only on `in_valid`:
- **P0**: latch `lo <= in_data`. Go to P1.
- **P1**: emit A = {in_data[3:0], lo}. Latch `nib <= in_data[7:4]`. Go to P2.
- **P2**: emit B = {in_data, nib}. Go to P0.

Other rules:
- `in_valid` low: no state change, no output. Gaps of any length are allowed between bytes.
- `resync` high: phase goes to P0. `lo` and `nib` are don't-care. No output is produced that cycle, even if `in_valid` is also high; the byte is dropped. `resync` has priority over `in_valid`.
- Encoding: P0=2'd0, P1=2'd1, P2=2'd2. Unreachable code 2'd3 returns to P0 on the next `in_valid` and produces no output.
- Reset values: phase=P0, `out_valid`=0, `out_data`=12'h000, `lo`=0, `nib`=0.
- Reset mid-triplet: the partial sample is lost and decoding restarts at byte0.

## Timing

- Latency: `out_valid` and `out_data` are registered. They assert on the cycle after the clock edge on which the completing byte (phase 1 or phase 2) is consumed.
- Throughput: up to 1 byte per cycle. With continuous input, `out_valid` pattern is 0,1,1 repeating per 3 cycles (2 samples per 3 cycles).
- `out_valid` is high for exactly one cycle per sample.
- `out_data` holds its last value while `out_valid` is low.
- `phase` is the registered state. It reflects the phase of the next byte to be consumed.
- `nreset` deasserts asynchronously-assert/synchronously-release at the system level. The block needs no synchronizer of its own.

## Structure

- Shared constants header/package: `SAMPLE_W=12`, `BYTE_W=8`, and the phase encodings `PH_0`/`PH_1`/`PH_2`. The packer uses the same header so both ends agree on the format.
- Single flat module, no sub-modules: one state register, two holding registers (`lo[7:0]`, `nib[3:0]`), and the output registers.

## Test plan

- **Continuous ADC pattern.**
  - Stimulus: bytes 0x5A, 0xAA, 0xA5 repeated, `in_valid` held high.
  - Required response: `out_data`=0xA5A on every strobe, strobes in a 0,1,1 pattern, `phase` cycling 0,1,2.
- **Distinct pair.**
  - Stimulus: bytes 0x34, 0x12, 0xAB.
  - Required response: A=0x234 one cycle after byte1, then B=0xAB1 one cycle after byte2.
- **Gaps.**
  - Stimulus: the same bytes as the distinct-pair case, with 0–5 idle cycles of `in_valid` low inserted randomly between them.
  - Required response: identical samples. No `out_valid` during gaps. `out_data` holds its last value.
- **Resync mid-triplet.**
  - Stimulus: bytes 0x34, 0x12; `resync` pulsed; then 0x78, 0x56, 0xCD.
  - Required response: A=0x234, then after the resync A=0x678 and B=0xCD5. No spurious strobe on the resync cycle.
- **Reset mid-operation.**
  - Stimulus: after byte0 is consumed, assert `nreset`=0 asynchronously between clock edges.
  - Required response: outputs immediately go to `out_valid`=0, `out_data`=0, `phase`=0. After release, the next 3 bytes decode correctly as a fresh triplet.
- **Round trip.**
  - Stimulus: the packer fed by the ADC block with a 1000-sample random pattern, its output driving this block.
  - Required response: the output sample sequence equals the input sample sequence exactly.

Source files
------------

// File: rtl/unpacker_8to12_pkg.sv
// Packing format shared by the 12-to-8 packer and the 8-to-12 unpacker.
// Three bytes carry two 12-bit samples, little-endian.
package unpacker_8to12_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NIB_W    = SAMPLE_W - BYTE_W;

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2
  } phase_e;

endpackage

// File: rtl/unpacker_8to12_if.sv
// Byte-in / sample-out strobe bus of the unpacker; the master drives bytes and resync.
interface unpacker_8to12_if;
  import unpacker_8to12_pkg::*;

  logic [BYTE_W-1:0]   in_data;
  logic                in_valid;
  logic                resync;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic [1:0]          phase;

  modport master (
    output in_data, in_valid, resync,
    input  out_data, out_valid, phase
  );

  modport slave (
    input  in_data, in_valid, resync,
    output out_data, out_valid, phase
  );

endinterface

// File: rtl/unpacker_8to12.sv
// Rebuilds 12-bit samples from the packed byte stream; outputs registered one cycle after the completing byte.
// No backpressure: every in_valid byte is consumed, resync drops the byte and returns to phase 0.
module unpacker_8to12
  import unpacker_8to12_pkg::*;
(
  input logic             clk,
  input logic             nreset,
  unpacker_8to12_if.slave bus
);

  phase_e              state_q, state_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [NIB_W-1:0]    nib_q, nib_d;
  logic                emit;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] out_data_q;
  logic                out_valid_q;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    nib_d   = nib_q;
    emit    = 1'b0;
    sample  = out_data_q;
    // resync wins over a coincident byte, which is discarded
    if (bus.resync) begin
      state_d = PH_0;
    end else if (bus.in_valid) begin
      case (state_q)
        PH_0: begin
          lo_d    = bus.in_data;
          state_d = PH_1;
        end
        PH_1: begin
          emit    = 1'b1;
          sample  = {bus.in_data[NIB_W-1:0], lo_q};
          nib_d   = bus.in_data[BYTE_W-1:NIB_W];
          state_d = PH_2;
        end
        PH_2: begin
          emit    = 1'b1;
          sample  = {bus.in_data, nib_q};
          state_d = PH_0;
        end
        default: state_d = PH_0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= PH_0;
      lo_q        <= '0;
      nib_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      nib_q       <= nib_d;
      out_valid_q <= emit;
      out_data_q  <= sample;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.phase     = state_q;

endmodule

// File: tb/tb_unpacker_8to12.sv
// Directed bench for unpacker_8to12: fixed byte vectors with hand-computed samples, plus a packed random round trip.
module tb_unpacker_8to12;

  logic clk;
  logic nreset;
  int   n_checks;
  int   n_errors;

  logic [11:0] hold_dat;
  logic [1:0]  exp_ph;

  unpacker_8to12_if bus ();

  unpacker_8to12 dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one byte for one clock, then checks the registered outputs #1 after the edge.
  task automatic send_exp(input string tag, input logic [7:0] b, input logic rsync,
                          input logic exp_vld, input logic [11:0] exp_dat);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.resync   = rsync;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.resync   = 1'b0;
    if (rsync) exp_ph = 2'd0;
    else       exp_ph = (exp_ph == 2'd2) ? 2'd0 : exp_ph + 2'd1;
    if (exp_vld) hold_dat = exp_dat;
    check({tag, "_vld"}, 16'(bus.out_valid), 16'(exp_vld));
    check({tag, "_dat"}, 16'(bus.out_data), 16'(hold_dat));
    check({tag, "_ph"},  16'(bus.phase), 16'(exp_ph));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hFF;
      @(posedge clk);
      #1;
      check({tag, "_vld"}, 16'(bus.out_valid), 16'd0);
      check({tag, "_dat"}, 16'(bus.out_data), 16'(hold_dat));
      check({tag, "_ph"},  16'(bus.phase), 16'(exp_ph));
    end
  endtask

  initial begin
    logic [11:0] a, b;
    n_checks     = 0;
    n_errors     = 0;
    hold_dat     = 12'h000;
    exp_ph       = 2'd0;
    nreset       = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.resync   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 16'(bus.out_valid), 16'd0);
    check("rst_dat", 16'(bus.out_data), 16'h000);
    check("rst_ph",  16'(bus.phase), 16'd0);
    @(negedge clk);
    nreset = 1'b1;

    // Continuous ADC pattern: 0xA5A every strobe, strobes 0,1,1
    for (int r = 0; r < 3; r++) begin
      send_exp("cont_b0", 8'h5A, 1'b0, 1'b0, 12'h000);
      send_exp("cont_b1", 8'hAA, 1'b0, 1'b1, 12'hA5A);
      send_exp("cont_b2", 8'hA5, 1'b0, 1'b1, 12'hA5A);
    end

    // Distinct pair
    send_exp("pair_b0", 8'h34, 1'b0, 1'b0, 12'h000);
    send_exp("pair_b1", 8'h12, 1'b0, 1'b1, 12'h234);
    send_exp("pair_b2", 8'hAB, 1'b0, 1'b1, 12'hAB1);

    // Same pair with random idle gaps
    for (int r = 0; r < 4; r++) begin
      idle("gap0", $urandom_range(0, 5));
      send_exp("gap_b0", 8'h34, 1'b0, 1'b0, 12'h000);
      idle("gap1", $urandom_range(0, 5));
      send_exp("gap_b1", 8'h12, 1'b0, 1'b1, 12'h234);
      idle("gap2", $urandom_range(0, 5));
      send_exp("gap_b2", 8'hAB, 1'b0, 1'b1, 12'hAB1);
    end

    // Resync mid-triplet, coincident with a byte that must be dropped
    send_exp("rs_b0", 8'h34, 1'b0, 1'b0, 12'h000);
    send_exp("rs_b1", 8'h12, 1'b0, 1'b1, 12'h234);
    send_exp("rs_pulse", 8'hEE, 1'b1, 1'b0, 12'h000);
    send_exp("rs_n0", 8'h78, 1'b0, 1'b0, 12'h000);
    send_exp("rs_n1", 8'h56, 1'b0, 1'b1, 12'h678);
    send_exp("rs_n2", 8'hCD, 1'b0, 1'b1, 12'hCD5);
    // Resync with no byte after byte0
    send_exp("rs2_b0", 8'h99, 1'b0, 1'b0, 12'h000);
    @(negedge clk);
    bus.resync = 1'b1;
    @(posedge clk);
    #1;
    bus.resync = 1'b0;
    exp_ph = 2'd0;
    check("rs2_vld", 16'(bus.out_valid), 16'd0);
    check("rs2_ph",  16'(bus.phase), 16'd0);

    // Asynchronous reset after byte0 of a triplet
    send_exp("rm_b0", 8'h9A, 1'b0, 1'b0, 12'h000);
    #2;
    nreset = 1'b0;
    #1;
    hold_dat = 12'h000;
    exp_ph   = 2'd0;
    check("rm_vld", 16'(bus.out_valid), 16'd0);
    check("rm_dat", 16'(bus.out_data), 16'h000);
    check("rm_ph",  16'(bus.phase), 16'd0);
    @(negedge clk);
    nreset = 1'b1;
    send_exp("rm_f0", 8'h34, 1'b0, 1'b0, 12'h000);
    send_exp("rm_f1", 8'h12, 1'b0, 1'b1, 12'h234);
    send_exp("rm_f2", 8'hAB, 1'b0, 1'b1, 12'hAB1);

    // Round trip: 1000 random samples packed as the packer would
    for (int i = 0; i < 500; i++) begin
      a = 12'($urandom);
      b = 12'($urandom);
      send_exp("rt_b0", a[7:0], 1'b0, 1'b0, 12'h000);
      send_exp("rt_a",  {b[3:0], a[11:8]}, 1'b0, 1'b1, a);
      send_exp("rt_b",  b[11:4], 1'b0, 1'b1, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
